// File: rtl/rsp_lden_pkg.sv
// Shared types and constants for the RSP load-enable generator.
package rsp_lden_pkg;

   typedef enum logic [0:0] {IDLE, BURST} lden_state_t;

   localparam int unsigned LDEN_MAX_DEPTH = 256;
   localparam logic [LDEN_MAX_DEPTH-1:0] LDEN_ALL_OFF = '1;

endpackage

// File: rtl/rsp_lden_cgate.sv
// Clock-phase gate for one latch enable line: en_f = ld_bar | clk.
// Behavioural stand-in for a single or02d2 cell so the gate stays a distinct instance.
module rsp_lden_cgate (
   input  logic i_a,
   input  logic i_b,
   output logic o_z
);

   assign o_z = i_a | i_b;

endmodule

// File: rtl/rsp_lden_burst_gen.sv
// Load-enable generator: one-hot active-low ld_bar with single/burst sequencing, stall and wrap.
// Define RSP_LDEN_CGATE_EN to add the clock-gated latch enables on o_en_f.
module rsp_lden_burst_gen
   import rsp_lden_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned BLW   = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_wr_valid,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [BLW-1:0]   i_burst_len,
   input  logic             i_stall,
   output logic             o_wr_busy,
   output logic             o_wr_done,
   output logic [AW-1:0]    o_cur_addr,
   output logic [DEPTH-1:0] o_ld_bar
`ifdef RSP_LDEN_CGATE_EN
   ,
   output logic [DEPTH-1:0] o_en_f
`endif
);

   lden_state_t      r_state, w_state_nxt;
   logic [AW-1:0]    r_addr, w_addr_nxt;
   logic [BLW-1:0]   r_cnt, w_cnt_nxt;
   logic             w_issue;
   logic             w_last;
   logic [AW-1:0]    w_issue_addr;
   logic [DEPTH-1:0] w_ld_bar_nxt;
   logic [DEPTH-1:0] r_ld_bar;
   logic             r_done;
   logic [AW-1:0]    r_cur_addr;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // BURST means entries remain to be issued; r_addr/r_cnt describe the next one to issue.
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (i_wr_valid) begin
               if (i_stall) begin
                  w_state_nxt = BURST;
                  w_addr_nxt  = i_wr_addr;
                  w_cnt_nxt   = i_burst_len;
               end else begin
                  w_addr_nxt = i_wr_addr + 1'b1;
                  w_cnt_nxt  = i_burst_len - 1'b1;
                  if (i_burst_len != '0) w_state_nxt = BURST;
               end
            end
         end
         BURST: begin
            if (!i_stall) begin
               w_addr_nxt = r_addr + 1'b1;
               if (r_cnt == '0) w_state_nxt = IDLE;
               else             w_cnt_nxt   = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_issue      = 1'b0;
      w_last       = 1'b0;
      w_issue_addr = r_addr;
      unique case (r_state)
         IDLE: begin
            if (i_wr_valid && !i_stall) begin
               w_issue      = 1'b1;
               w_issue_addr = i_wr_addr;
               w_last       = (i_burst_len == '0);
            end
         end
         BURST: begin
            if (!i_stall) begin
               w_issue = 1'b1;
               w_last  = (r_cnt == '0);
            end
         end
         default: ;
      endcase
   end

   // Addresses at or above DEPTH match no line, so the slot passes with ld_bar all-ones.
   always_comb begin
      w_ld_bar_nxt = LDEN_ALL_OFF[DEPTH-1:0];
      if (w_issue) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_issue_addr == AW'(k)) w_ld_bar_nxt[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ld_bar   <= LDEN_ALL_OFF[DEPTH-1:0];
         r_done     <= 1'b0;
         r_cur_addr <= '0;
      end else begin
         r_ld_bar <= w_ld_bar_nxt;
         r_done   <= w_issue & w_last;
         if (w_issue) r_cur_addr <= w_issue_addr;
      end
   end

   assign o_wr_busy  = (r_state == BURST);
   assign o_wr_done  = r_done;
   assign o_cur_addr = r_cur_addr;
   assign o_ld_bar   = r_ld_bar;

`ifdef RSP_LDEN_CGATE_EN
   // ld_bar only moves while clk is high, so the OR output cannot glitch low.
   for (genvar g = 0; g < DEPTH; g++) begin : g_cgate
      rsp_lden_cgate u_cgate (
         .i_a (r_ld_bar[g]),
         .i_b (i_clk),
         .o_z (o_en_f[g])
      );
   end
`endif

endmodule

// File: tb/tb_rsp_lden_burst_gen.sv
// Directed scoreboard bench: two instances (DEPTH=32 and DEPTH=20) share all stimulus.
module tb_rsp_lden_burst_gen;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_wr_valid = 1'b0;
   logic [4:0]  i_wr_addr = '0;
   logic [3:0]  i_burst_len = '0;
   logic        i_stall = 1'b0;

   logic        busy32, done32, busy20, done20;
   logic [4:0]  cur32, cur20;
   logic [31:0] ld32;
   logic [19:0] ld20;
`ifdef RSP_LDEN_CGATE_EN
   logic [31:0] en32;
   logic [19:0] en20;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int ent;
      bit done;
      bit busy;
      bit chk_busy;
      bit chk_cur;
      int cur;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   rsp_lden_burst_gen #(.DEPTH(32), .AW(5), .BLW(4)) dut32 (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_wr_valid  (i_wr_valid),
      .i_wr_addr   (i_wr_addr),
      .i_burst_len (i_burst_len),
      .i_stall     (i_stall),
      .o_wr_busy   (busy32),
      .o_wr_done   (done32),
      .o_cur_addr  (cur32),
      .o_ld_bar    (ld32)
`ifdef RSP_LDEN_CGATE_EN
      ,
      .o_en_f      (en32)
`endif
   );

   rsp_lden_burst_gen #(.DEPTH(20), .AW(5), .BLW(4)) dut20 (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_wr_valid  (i_wr_valid),
      .i_wr_addr   (i_wr_addr),
      .i_burst_len (i_burst_len),
      .i_stall     (i_stall),
      .o_wr_busy   (busy20),
      .o_wr_done   (done20),
      .o_cur_addr  (cur20),
      .o_ld_bar    (ld20)
`ifdef RSP_LDEN_CGATE_EN
      ,
      .o_en_f      (en20)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int ent, input bit done, input bit busy, input bit chk_busy,
                       input bit chk_cur, input int cur);
      exp_t e;
      e.ent = ent; e.done = done; e.busy = busy;
      e.chk_busy = chk_busy; e.chk_cur = chk_cur; e.cur = cur;
      sbq.push_back(e);
   endtask

   // Expect entry 'ent' loaded in the next cycle.
   task automatic ld(input int ent, input bit done, input bit busy);
      push(ent, done, busy, 1'b1, 1'b1, ent);
   endtask

   // Expect no entry loaded in the next cycle.
   task automatic nl(input bit busy);
      push(-1, 1'b0, busy, 1'b1, 1'b0, 0);
   endtask

   task automatic step(input bit v, input int a, input int l, input bit s, input bit r);
      exp_t        e;
      logic [31:0] exp32;
      logic [19:0] exp20;
      i_reset     = r;
      i_wr_valid  = v;
      i_wr_addr   = a[4:0];
      i_burst_len = l[3:0];
      i_stall     = s;
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 32'(sbq.size()), 32'd1);
      end else begin
         e = sbq.pop_front();
         exp32 = '1;
         exp20 = '1;
         if (e.ent >= 0) exp32[e.ent] = 1'b0;
         if (e.ent >= 0 && e.ent < 20) exp20[e.ent] = 1'b0;
         chk("ld_bar32", ld32, exp32);
         chk("ld_bar20", 32'(ld20), 32'(exp20));
         chk("wr_done32", 32'(done32), 32'(e.done));
         chk("wr_done20", 32'(done20), 32'(e.done));
         if (e.chk_busy) begin
            chk("wr_busy32", 32'(busy32), 32'(e.busy));
            chk("wr_busy20", 32'(busy20), 32'(e.busy));
         end
         if (e.chk_cur) begin
            chk("cur_addr32", 32'(cur32), 32'(e.cur));
            chk("cur_addr20", 32'(cur20), 32'(e.cur));
         end
`ifdef RSP_LDEN_CGATE_EN
         chk("en_f32_clk_high", en32, 32'hffff_ffff);
         chk("en_f20_clk_high", 32'(en20), 32'h000f_ffff);
         #5;
         chk("en_f32_clk_low", en32, exp32);
         chk("en_f20_clk_low", 32'(en20), 32'(exp20));
`endif
      end
   endtask

   initial begin
      // Reset state
      push(-1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      step(1'b0, 0, 0, 1'b0, 1'b1);
      push(-1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      step(1'b0, 0, 0, 1'b0, 1'b1);

      // Single write
      ld(5, 1'b1, 1'b0);  step(1'b1, 5, 0, 1'b0, 1'b0);
      nl(1'b0);           step(1'b0, 0, 0, 1'b0, 1'b0);

      // Burst with wrap 30,31,0,1
      ld(30, 1'b0, 1'b1); step(1'b1, 30, 3, 1'b0, 1'b0);
      ld(31, 1'b0, 1'b1); step(1'b0, 0, 0, 1'b0, 1'b0);
      ld(0, 1'b0, 1'b1);  step(1'b0, 0, 0, 1'b0, 1'b0);
      ld(1, 1'b1, 1'b0);  step(1'b0, 0, 0, 1'b0, 1'b0);
      nl(1'b0);           step(1'b0, 0, 0, 1'b0, 1'b0);

      // Stall in the middle of a burst
      ld(8, 1'b0, 1'b1);  step(1'b1, 8, 2, 1'b0, 1'b0);
      nl(1'b1);           step(1'b0, 0, 0, 1'b1, 1'b0);
      ld(9, 1'b0, 1'b1);  step(1'b0, 0, 0, 1'b0, 1'b0);
      ld(10, 1'b1, 1'b0); step(1'b0, 0, 0, 1'b0, 1'b0);
      nl(1'b0);           step(1'b0, 0, 0, 1'b0, 1'b0);

      // Request dropped while busy, then back-to-back accept
      ld(12, 1'b0, 1'b1); step(1'b1, 12, 2, 1'b0, 1'b0);
      ld(13, 1'b0, 1'b1); step(1'b1, 3, 0, 1'b0, 1'b0);
      ld(14, 1'b1, 1'b0); step(1'b0, 0, 0, 1'b0, 1'b0);
      ld(3, 1'b1, 1'b0);  step(1'b1, 3, 0, 1'b0, 1'b0);
      nl(1'b0);           step(1'b0, 0, 0, 1'b0, 1'b0);

      // Out-of-range entries for DEPTH=20
      ld(18, 1'b0, 1'b1); step(1'b1, 18, 3, 1'b0, 1'b0);
      ld(19, 1'b0, 1'b1); step(1'b0, 0, 0, 1'b0, 1'b0);
      ld(20, 1'b0, 1'b1); step(1'b0, 0, 0, 1'b0, 1'b0);
      ld(21, 1'b1, 1'b0); step(1'b0, 0, 0, 1'b0, 1'b0);
      nl(1'b0);           step(1'b0, 0, 0, 1'b0, 1'b0);

      // Stall in the request cycle: first load waits
      push(-1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
                          step(1'b1, 7, 0, 1'b1, 1'b0);
      ld(7, 1'b1, 1'b0);  step(1'b0, 0, 0, 1'b0, 1'b0);
      nl(1'b0);           step(1'b0, 0, 0, 1'b0, 1'b0);

      // Reset mid-burst: no partial wr_done, sequence does not resume
      ld(4, 1'b0, 1'b1);  step(1'b1, 4, 5, 1'b0, 1'b0);
      ld(5, 1'b0, 1'b1);  step(1'b0, 0, 0, 1'b0, 1'b0);
      push(-1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
                          step(1'b0, 0, 0, 1'b0, 1'b1);
      nl(1'b0);           step(1'b0, 0, 0, 1'b0, 1'b0);
      nl(1'b0);           step(1'b0, 0, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
